// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC update scheduler: FSM states, requester
// indices, BCD field positions and limits.
package rtc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StIssue,
        StDone
    } rtc_sched_state_e;

    localparam logic [1:0] REQ_CLOCK = 2'd0;
    localparam logic [1:0] REQ_ALARM = 2'd1;
    localparam logic [1:0] REQ_TIMER = 2'd2;

    localparam int unsigned HOUR_MSB = 21;
    localparam int unsigned HOUR_LSB = 16;
    localparam int unsigned MIN_MSB  = 15;
    localparam int unsigned MIN_LSB  = 8;
    localparam int unsigned SEC_MSB  = 7;
    localparam int unsigned SEC_LSB  = 0;

    localparam logic [7:0] MINSEC_MAX = 8'h59;
    localparam logic [5:0] HOUR_MAX   = 6'h23;

    // (base + off) mod 3, for base and off in 0..2.
    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational validity check of a 22-bit hh:mm:ss BCD time value.
module rtc_bcd_check
    import rtc_pkg::*;
(
    input  logic [21:0] time_i,
    output logic        valid_o
);

    logic [5:0] hour;
    logic [7:0] min;
    logic [7:0] sec;

    always_comb begin
        hour = time_i[HOUR_MSB:HOUR_LSB];
        min  = time_i[MIN_MSB:MIN_LSB];
        sec  = time_i[SEC_MSB:SEC_LSB];
        // The upper-bound compare already caps each tens digit; units need their own check.
        valid_o = (sec  <= MINSEC_MAX) && (sec[3:0]  <= 4'd9) &&
                  (min  <= MINSEC_MAX) && (min[3:0]  <= 4'd9) &&
                  (hour <= HOUR_MAX)   && (hour[3:0] <= 4'd9);
    end

endmodule

// File: rtl/rtc_update_sched.sv
// Round-robin scheduler sharing the rtc_clock update ports between clock, alarm and
// timer requesters; validates held data and defers the strobe away from the seconds tick.
module rtc_update_sched
    import rtc_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] ack_o,
    output logic            err_o,
    input  logic [21:0]     clock_data_i,
    input  logic [21:0]     alarm_data_i,
    input  logic [16:0]     timer_target_i,
    input  logic            timer_enable_i,
    input  logic            timer_retrig_i,
    input  logic            tick_i,
    output logic            clock_update_o,
    output logic [21:0]     clock_o,
    output logic            alarm_update_o,
    output logic [21:0]     alarm_clock_o,
    output logic            timer_update_o,
    output logic [16:0]     timer_target_o,
    output logic            timer_enable_o,
    output logic            timer_retrig_o,
    output logic            busy_o
);

    rtc_sched_state_e state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       mask_q, mask_d;
    logic             err_q, err_d;
    logic [21:0]      hold_q, hold_d;

    logic [21:0]      clock_q, clock_d;
    logic [21:0]      alarm_q, alarm_d;
    logic [16:0]      timer_target_q, timer_target_d;
    logic             timer_enable_q, timer_enable_d;
    logic             timer_retrig_q, timer_retrig_d;

    logic [2:0]       req_m;
    logic             gnt_found;
    logic [1:0]       gnt_idx;
    logic [21:0]      gnt_data;
    logic             bcd_valid;
    logic             timer_ok;
    logic             hold_valid;
    logic             issue;

    rtc_bcd_check u_bcd_check (
        .time_i  (hold_q),
        .valid_o (bcd_valid)
    );

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        req_m     = req_i & ~mask_q;
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_m[wrap_idx(rr_ptr_q, 2'(k))]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(rr_ptr_q, 2'(k));
            end
        end
        case (gnt_idx)
            REQ_CLOCK: gnt_data = clock_data_i;
            REQ_ALARM: gnt_data = alarm_data_i;
            default:   gnt_data = {3'b000, timer_retrig_i, timer_enable_i, timer_target_i};
        endcase
    end

    // Timer fields live in hold_q as {retrig, enable, target}.
    always_comb begin
        timer_ok   = !(hold_q[17] && (hold_q[16:0] == 17'd0));
        hold_valid = (grant_q == REQ_TIMER) ? timer_ok : bcd_valid;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        mask_d   = mask_q;
        err_d    = err_q;
        hold_d   = hold_q;
        unique case (state_q)
            StIdle: begin
                mask_d = 3'b000;
                if (gnt_found) begin
                    grant_d = gnt_idx;
                    hold_d  = gnt_data;
                    err_d   = 1'b0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (hold_valid) begin
                    state_d = StIssue;
                end else begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StIssue: begin
                if (!tick_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                rr_ptr_d = wrap_idx(grant_q, 2'd1);
                mask_d   = idx_onehot(grant_q);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes and acks are gated by rst_i so an aborted transaction emits nothing.
    always_comb begin
        issue          = (state_q == StIssue) && !tick_i && !rst_i;
        clock_update_o = issue && (grant_q == REQ_CLOCK);
        alarm_update_o = issue && (grant_q == REQ_ALARM);
        timer_update_o = issue && (grant_q == REQ_TIMER);

        clock_o        = clock_update_o ? hold_q        : clock_q;
        alarm_clock_o  = alarm_update_o ? hold_q        : alarm_q;
        timer_target_o = timer_update_o ? hold_q[16:0]  : timer_target_q;
        timer_enable_o = timer_update_o ? hold_q[17]    : timer_enable_q;
        timer_retrig_o = timer_update_o ? hold_q[18]    : timer_retrig_q;

        clock_d        = clock_o;
        alarm_d        = alarm_clock_o;
        timer_target_d = timer_target_o;
        timer_enable_d = timer_enable_o;
        timer_retrig_d = timer_retrig_o;

        ack_o  = ((state_q == StDone) && !rst_i) ? idx_onehot(grant_q) : 3'b000;
        err_o  = (state_q == StDone) && !rst_i && err_q;
        busy_o = (state_q != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            grant_q        <= 2'd0;
            rr_ptr_q       <= 2'd0;
            mask_q         <= 3'b000;
            err_q          <= 1'b0;
            hold_q         <= 22'd0;
            clock_q        <= 22'd0;
            alarm_q        <= 22'd0;
            timer_target_q <= 17'd0;
            timer_enable_q <= 1'b0;
            timer_retrig_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            rr_ptr_q       <= rr_ptr_d;
            mask_q         <= mask_d;
            err_q          <= err_d;
            hold_q         <= hold_d;
            clock_q        <= clock_d;
            alarm_q        <= alarm_d;
            timer_target_q <= timer_target_d;
            timer_enable_q <= timer_enable_d;
            timer_retrig_q <= timer_retrig_d;
        end
    end

endmodule

// File: tb/tb_rtc_update_sched.sv
// Scoreboard bench for rtc_update_sched: stimulus pushes expected strobes/acks with
// absolute cycle numbers; a negedge monitor pops and compares whatever the DUT presents.
module tb_rtc_update_sched;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  req_i = 3'b000;
    logic [2:0]  ack_o;
    logic        err_o;
    logic [21:0] clock_data_i = 22'd0;
    logic [21:0] alarm_data_i = 22'd0;
    logic [16:0] timer_target_i = 17'd0;
    logic        timer_enable_i = 1'b0;
    logic        timer_retrig_i = 1'b0;
    logic        tick_i = 1'b0;
    logic        clock_update_o;
    logic [21:0] clock_o;
    logic        alarm_update_o;
    logic [21:0] alarm_clock_o;
    logic        timer_update_o;
    logic [16:0] timer_target_o;
    logic        timer_enable_o;
    logic        timer_retrig_o;
    logic        busy_o;

    rtc_update_sched #(.NREQ(3)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .ack_o          (ack_o),
        .err_o          (err_o),
        .clock_data_i   (clock_data_i),
        .alarm_data_i   (alarm_data_i),
        .timer_target_i (timer_target_i),
        .timer_enable_i (timer_enable_i),
        .timer_retrig_i (timer_retrig_i),
        .tick_i         (tick_i),
        .clock_update_o (clock_update_o),
        .clock_o        (clock_o),
        .alarm_update_o (alarm_update_o),
        .alarm_clock_o  (alarm_clock_o),
        .timer_update_o (timer_update_o),
        .timer_target_o (timer_target_o),
        .timer_enable_o (timer_enable_o),
        .timer_retrig_o (timer_retrig_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_ack;
        logic [2:0]  which;
        logic        err;
        logic [21:0] data;
        logic [16:0] tt;
        logic        te;
        logic        tr;
    } exp_t;

    exp_t q[$];
    int   npass  = 0;
    int   ntotal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic exp_upd(input int c, input logic [2:0] w, input logic [21:0] d,
                           input logic [16:0] tt, input logic te, input logic tr);
        exp_t e;
        e.cyc = c; e.is_ack = 1'b0; e.which = w; e.err = 1'b0;
        e.data = d; e.tt = tt; e.te = te; e.tr = tr;
        q.push_back(e);
    endtask

    task automatic exp_ack(input int c, input logic [2:0] w, input logic er);
        exp_t e;
        e.cyc = c; e.is_ack = 1'b1; e.which = w; e.err = er;
        e.data = 22'd0; e.tt = 17'd0; e.te = 1'b0; e.tr = 1'b0;
        q.push_back(e);
    endtask

    // Monitor: every strobe or ack must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [2:0] upd;
        exp_t       e;
        upd = {timer_update_o, alarm_update_o, clock_update_o};
        if (upd != 3'b000) begin
            chk("strobe_vs_tick", {31'd0, tick_i}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, upd}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("strobe_kind", {31'd0, e.is_ack}, 32'd0);
                chk("strobe_sel", {29'd0, upd}, {29'd0, e.which});
                chk("strobe_cycle", cyc, e.cyc);
                if (upd == 3'b001) chk("clock_o", {10'd0, clock_o}, {10'd0, e.data});
                else if (upd == 3'b010) chk("alarm_clock_o", {10'd0, alarm_clock_o}, {10'd0, e.data});
                else chk("timer_out", {13'd0, timer_retrig_o, timer_enable_o, timer_target_o},
                         {13'd0, e.tr, e.te, e.tt});
            end
        end
        if (ack_o != 3'b000) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {29'd0, ack_o}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("ack_kind", {31'd0, e.is_ack}, 32'd1);
                chk("ack_sel", {29'd0, ack_o}, {29'd0, e.which});
                chk("ack_err", {31'd0, err_o}, {31'd0, e.err});
                chk("ack_cycle", cyc, e.cyc);
            end
        end else if (err_o) begin
            chk("err_without_ack", {31'd0, err_o}, 32'd0);
        end
    end

    task automatic start(output int c0);
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask

    // Requesters hold req until they see their ack, then drop it the next cycle.
    task automatic run_reqs(input logic [2:0] set);
        logic [2:0] seen;
        int n;
        req_i = set;
        n = 0;
        while (req_i != 3'b000 && n < 200) begin
            @(negedge clk);
            seen = ack_o;
            @(posedge clk);
            #1;
            req_i = req_i & ~seen;
            n++;
        end
        if (req_i != 3'b000) begin
            chk("req_timeout", {29'd0, req_i}, 32'd0);
            req_i = 3'b000;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    logic [21:0] al_tab [0:6] = '{22'h070809, 22'h00005A, 22'h240000, 22'h000A00,
                                  22'h0A0000, 22'h000060, 22'h235959};
    bit          al_ok  [0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          c0;
        logic [21:0] last_alarm;

        do_reset();
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ack", {29'd0, ack_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_strobes", {29'd0, timer_update_o, alarm_update_o, clock_update_o}, 32'd0);
        chk("rst_clock_o", {10'd0, clock_o}, 32'd0);
        chk("rst_alarm_o", {10'd0, alarm_clock_o}, 32'd0);
        chk("rst_timer_o", {13'd0, timer_retrig_o, timer_enable_o, timer_target_o}, 32'd0);

        // Basic clock set.
        start(c0);
        clock_data_i = 22'h123456;
        exp_upd(c0 + 2, 3'b001, 22'h123456, 17'd0, 1'b0, 1'b0);
        exp_ack(c0 + 3, 3'b001, 1'b0);
        run_reqs(3'b001);

        // Alarm validity table; alarm output must keep the last valid value.
        last_alarm = 22'd0;
        for (int i = 0; i < 7; i++) begin
            start(c0);
            alarm_data_i = al_tab[i];
            if (al_ok[i]) begin
                exp_upd(c0 + 2, 3'b010, al_tab[i], 17'd0, 1'b0, 1'b0);
                exp_ack(c0 + 3, 3'b010, 1'b0);
                last_alarm = al_tab[i];
            end else begin
                exp_ack(c0 + 2, 3'b010, 1'b1);
            end
            run_reqs(3'b010);
            chk("alarm_hold", {10'd0, alarm_clock_o}, {10'd0, last_alarm});
        end

        // All three together from reset, twice: order 0, 1, 2 each round.
        do_reset();
        clock_data_i   = 22'h010203;
        alarm_data_i   = 22'h040506;
        timer_target_i = 17'h00123;
        timer_enable_i = 1'b1;
        timer_retrig_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            start(c0);
            exp_upd(c0 + 2,  3'b001, 22'h010203, 17'd0, 1'b0, 1'b0);
            exp_ack(c0 + 3,  3'b001, 1'b0);
            exp_upd(c0 + 6,  3'b010, 22'h040506, 17'd0, 1'b0, 1'b0);
            exp_ack(c0 + 7,  3'b010, 1'b0);
            exp_upd(c0 + 10, 3'b100, 22'd0, 17'h00123, 1'b1, 1'b0);
            exp_ack(c0 + 11, 3'b100, 1'b0);
            run_reqs(3'b111);
        end

        // Clock req held through its ack: masked for one IDLE cycle, regranted a cycle late.
        start(c0);
        clock_data_i = 22'h225900;
        exp_upd(c0 + 2, 3'b001, 22'h225900, 17'd0, 1'b0, 1'b0);
        exp_ack(c0 + 3, 3'b001, 1'b0);
        exp_upd(c0 + 7, 3'b001, 22'h225900, 17'd0, 1'b0, 1'b0);
        exp_ack(c0 + 8, 3'b001, 1'b0);
        req_i = 3'b001;
        repeat (9) @(posedge clk);
        #1;
        req_i = 3'b000;

        // Tick high for three ISSUE cycles pushes the strobe to cycle 5.
        start(c0);
        clock_data_i = 22'h000001;
        exp_upd(c0 + 5, 3'b001, 22'h000001, 17'd0, 1'b0, 1'b0);
        exp_ack(c0 + 6, 3'b001, 1'b0);
        fork
            run_reqs(3'b001);
            begin
                repeat (2) @(posedge clk);
                #1 tick_i = 1'b1;
                repeat (3) @(posedge clk);
                #1 tick_i = 1'b0;
            end
        join

        // Timer: enabled with zero target is rejected; disabled zero and max target accepted.
        start(c0);
        timer_target_i = 17'd0; timer_enable_i = 1'b1; timer_retrig_i = 1'b0;
        exp_ack(c0 + 2, 3'b100, 1'b1);
        run_reqs(3'b100);
        chk("timer_hold", {13'd0, timer_retrig_o, timer_enable_o, timer_target_o},
            {13'd0, 1'b0, 1'b1, 17'h00123});

        start(c0);
        timer_target_i = 17'd0; timer_enable_i = 1'b0; timer_retrig_i = 1'b0;
        exp_upd(c0 + 2, 3'b100, 22'd0, 17'd0, 1'b0, 1'b0);
        exp_ack(c0 + 3, 3'b100, 1'b0);
        run_reqs(3'b100);

        start(c0);
        timer_target_i = 17'h1FFFF; timer_enable_i = 1'b1; timer_retrig_i = 1'b1;
        exp_upd(c0 + 2, 3'b100, 22'd0, 17'h1FFFF, 1'b1, 1'b1);
        exp_ack(c0 + 3, 3'b100, 1'b0);
        run_reqs(3'b100);

        // Move rr_ptr to 2 so the post-reset grant order shows it was cleared.
        start(c0);
        alarm_data_i = 22'h000102;
        exp_upd(c0 + 2, 3'b010, 22'h000102, 17'd0, 1'b0, 1'b0);
        exp_ack(c0 + 3, 3'b010, 1'b0);
        run_reqs(3'b010);

        // Reset during ISSUE: nothing emitted, idle next cycle.
        start(c0);
        clock_data_i = 22'h111111;
        req_i = 3'b001;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        req_i = 3'b000;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);

        start(c0);
        alarm_data_i   = 22'h010000;
        timer_target_i = 17'd5; timer_enable_i = 1'b1; timer_retrig_i = 1'b0;
        exp_upd(c0 + 2, 3'b010, 22'h010000, 17'd0, 1'b0, 1'b0);
        exp_ack(c0 + 3, 3'b010, 1'b0);
        exp_upd(c0 + 6, 3'b100, 22'd0, 17'd5, 1'b1, 1'b0);
        exp_ack(c0 + 7, 3'b100, 1'b0);
        run_reqs(3'b110);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/rtc_update_sched.md
# rtc_update_sched

Scheduler that shares the single set of `rtc_clock` update ports between three software-facing requesters: clock set, alarm set and timer set. It arbitrates round-robin and validates BCD time values before issuing them. It delays any issue that would coincide with the RTC seconds tick, then drives a one-cycle update strobe into `rtc_clock`. It sits between the APB register file and `rtc_clock`.

## Interface
Parameters:
- `NREQ`, 3: number of requesters, fixed at 3. Index 0 = clock, 1 = alarm, 2 = timer.

Ports:
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, synchronous, active-high.
- `req_i`  in  3: level requests, one per requester.
- `ack_o`  out  3: one-cycle completion pulse, one-hot.
- `err_o`  out  1: valid only with `ack_o`. 1 means the request was rejected and nothing was issued.
- `clock_data_i`  in  22: new time for requester 0.
- `alarm_data_i`  in  22: new alarm time for requester 1.
- `timer_target_i`  in  17: timer target for requester 2.
- `timer_enable_i`  in  1: timer enable for requester 2.
- `timer_retrig_i`  in  1: timer retrigger for requester 2.
- `tick_i`  in  1: seconds strobe from `rtc_clock`.
- `clock_update_o`  out  1: update strobe to `rtc_clock` clock port.
- `clock_o`  out  22: clock data to `rtc_clock`.
- `alarm_update_o`  out  1: update strobe to `rtc_clock` alarm port.
- `alarm_clock_o`  out  22: alarm data to `rtc_clock`.
- `timer_update_o`  out  1: update strobe to `rtc_clock` timer port.
- `timer_target_o`  out  17: timer target to `rtc_clock`.
- `timer_enable_o`  out  1: timer enable to `rtc_clock`.
- `timer_retrig_o`  out  1: timer retrigger to `rtc_clock`.
- `busy_o`  out  1: high in every state other than IDLE.

## Operation
- Time format (22 bits): [21:16] hours BCD (2-bit tens, 4-bit units), [15:8] minutes BCD, [7:0] seconds BCD.
- A time is valid only if all of these hold:
  - seconds ≤ 0x59, with each nibble ≤ 9;
  - minutes ≤ 0x59, with each nibble ≤ 9;
  - hours ≤ 0x23, with units ≤ 9.
- Timer request validity: invalid if `timer_enable_i`=1 and `timer_target_i`=0; otherwise always valid.
- FSM states: IDLE, CHECK, ISSUE, DONE.
  - IDLE: if any unmasked `req_i` bit is set, grant the first set index at or after `rr_ptr`. Latch the granted requester's data into a holding register. Go to CHECK.
  - CHECK: validate the held data. If valid, go to ISSUE. If invalid, set `err` and go to DONE.
  - ISSUE: if `tick_i`=1, stay in ISSUE and issue nothing. Otherwise pulse exactly one `*_update_o`, selected by the grant, for one cycle, then go to DONE.
  - DONE: pulse `ack_o[grant]` with `err_o`. Set `rr_ptr` = (grant+1) mod 3. Go to IDLE.
- Masking: in the first IDLE cycle after DONE, the just-acked index is masked. Requesters drop `req_i` on the cycle after they see `ack_o`.
- Data outputs hold the last issued values. They change only in the cycle where the matching `*_update_o` is high.
- Requester data must be stable while its `req_i` is high. Data is latched once, at grant.
- Changes to `req_i` of non-granted requesters during a transaction are ignored until IDLE.

## Timing
- Reset values: all strobes 0, `ack_o`=0, `err_o`=0, `busy_o`=0, all data outputs 0, `rr_ptr`=0, state IDLE.
- Valid request, `req_i` first high in cycle 0 while IDLE, no tick:
  - CHECK in cycle 1;
  - `*_update_o` high in cycle 2;
  - `ack_o` high in cycle 3;
  - earliest next grant in cycle 4.
- Invalid request: `ack_o` and `err_o` high in cycle 2. No update strobe.
- Each cycle `tick_i` is high during ISSUE adds one cycle of latency. There is no timeout.
- Simultaneous requests: round-robin from `rr_ptr`. No requester waits more than 2 transactions.
- `rst_i` mid-transaction: return to IDLE the next cycle. No strobe or ack is emitted and the pending grant is dropped.

## Structure
- Package `rtc_pkg` holds:
  - the state enum `rtc_sched_state_e`;
  - requester index constants `REQ_CLOCK`, `REQ_ALARM`, `REQ_TIMER`;
  - BCD field ranges `HOUR_MSB/LSB`, `MIN_MSB/LSB`, `SEC_MSB/LSB`;
  - the limit constants 0x59 and 0x23.
- One combinational sub-module, `rtc_bcd_check` (22-bit in, `valid` out). It is instantiated once on the holding register.

## Test plan
- Reset, then clock req with 0x12_34_56 → `clock_update_o` in cycle 2 with `clock_o`=0x123456, `ack_o`=001 in cycle 3, `err_o`=0.
- Alarm req with seconds 0x5A, then separately with hours 0x24 → `ack_o`=010 with `err_o`=1 in cycle 2 each time, no `alarm_update_o`, `alarm_clock_o` unchanged.
- All three `req_i` high together from reset → grants in order 0, 1, 2. Then re-assert all → order 0, 1, 2 again, with the just-acked index masked between grants.
- Clock req with `tick_i` high for 3 cycles during ISSUE → strobe delayed to cycle 5, never coincident with `tick_i`.
- Timer req with enable=1, target=0 → `err_o`=1. Then target 0x1FFFF, enable=1, retrig=1 → `timer_update_o` with those exact values.
- `rst_i` asserted in cycle 2 (ISSUE) → no strobe, no ack, `busy_o`=0 the next cycle, `rr_ptr`=0.
